fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single write port of one FIFO between
//  NREQ producers. Grants are burst-locked: one owner for up to MAX_BURST beats.
//  Writes are issued only while the FIFO full flag is low, so the FIFO overflow
//  status never asserts. Sits between the producer blocks and the FIFO wr/din port.
// PARAMETERS
//  NREQ      4   number of requesters (2..8)
//  WIDTH     8   data width per requester and on the FIFO port
//  MAX_BURST 4   maximum beats per grant (>=1)
// PORTS
//  clk       in   1           clock, all logic on rising edge
//  rst       in   1           synchronous reset, active-high
//  req       in   NREQ        req[i]=1: requester i has a word on din slice i
//  din       in   NREQ*WIDTH  requester i data on din[i*WIDTH +: WIDTH]
//  fifo_full in   1           full flag from the FIFO status logic
//  grant     out  NREQ        one-hot owner; all zero when idle (registered)
//  ack       out  NREQ        ack[i]=1: word i written this cycle (combinational)
//  fifo_wr   out  1           FIFO write strobe (combinational)
//  fifo_din  out  WIDTH       data to FIFO = owner's din slice; 0 when idle
//  busy      out  1           1 while in GRANT state (registered)
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE, grant=0, busy=0, beat count=0,
//   last_owner=NREQ-1, so requester 0 has top priority first. ack/fifo_wr=0 while idle.
//  Reset mid-burst: the burst is abandoned at that edge and no write occurs in
//   the following cycle.
//  Beat: beat = busy & req[owner] & ~fifo_full.
//   fifo_wr = beat; ack = grant & {NREQ{beat}}.
//  RR pick from a vector v: the first set bit searching last_owner+1, +2, ...,
//   wrapping modulo NREQ. last_owner itself is checked last.
//  FSM, two states:
//   IDLE: if |req, then next edge: GRANT, grant=onehot(pick(req)), count=0,
//    last_owner=pick. One-cycle grant latency, and no write in the IDLE cycle.
//   GRANT: on each edge, evaluate:
//    end = ~req[owner] | (beat & count==MAX_BURST-1)
//    if !end: stay; count += beat. A stall (fifo_full=1) freezes count and
//     keeps grant.
//    if end and |req: re-grant pick(req) at the same edge with count=0 (no idle
//     bubble). A sole requester is re-granted to itself.
//    if end and ~|req: go to IDLE, grant=0.
//  The owner dropping req ends its burst without a beat in that cycle.
//  count width = $clog2(MAX_BURST+1); count never exceeds MAX_BURST-1.
//  fifo_full during the last beat: no beat, no end; the burst waits.
//  Non-owner requests never produce ack. Requesters hold req/din until acked.
//  Invariants: grant is one-hot or zero; fifo_wr & fifo_full == 0 always;
//   at most one ack bit per cycle.
// TESTING
//  1 rst, then req=4'b1111 held, full=0 -> grant 0001 one cycle later with 4 acks,
//    then 0010, 0100, 1000, 0001 back-to-back with no gap cycles.
//  2 only req[2] held -> grant 0100 continuously; ack[2] every cycle from the
//    first grant; count wraps 0..3 repeatedly.
//  3 owner 0 after 2 beats, fifo_full=1 for 3 cycles -> fifo_wr=0, ack=0, grant
//    held 0001; full=0 -> exactly 2 more beats, then grant moves on.
//  4 owner 1 drops req after 1 beat, req[3]=1 -> next edge grant=1000, count=0;
//    exactly 1 ack[1] in total.
//  5 rst=1 mid-burst of owner 2 -> grant=0, busy=0 next cycle; with req=1111 the
//    next grant is 0001.
//  6 random req/full for 10k cycles: check invariants, ack count equals FIFO write
//    count, and no requester waits more than (NREQ-1)*MAX_BURST beats + 1 grant.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO write port between NREQ producers.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] din,
  input  logic                  fifo_full,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       ack,
  output logic                  fifo_wr,
  output logic [WIDTH-1:0]      fifo_din,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam int unsigned OWN_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_e;

  state_e             state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [OWN_W-1:0]   last_q,  last_d;
  logic               busy_q,  busy_d;

  logic               owner_req_c;
  logic [WIDTH-1:0]   din_sel_c;
  logic               beat_c;
  logic               end_c;
  logic [OWN_W-1:0]   pick_c;
  logic               found_hi_c, found_lo_c;
  logic [OWN_W-1:0]   hi_idx_c, lo_idx_c;

  // Owner's request bit and data slice, selected by the one-hot grant
  always_comb begin
    owner_req_c = |(req & grant_q);
    din_sel_c   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant_q[i]) begin
        din_sel_c = din_sel_c | din[i*WIDTH +: WIDTH];
      end
    end
  end

  // Round-robin pick: first requester above last_q, else first at or below it (last_q itself last)
  always_comb begin
    found_hi_c = 1'b0;
    found_lo_c = 1'b0;
    hi_idx_c   = '0;
    lo_idx_c   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (req[i]) begin
        if (OWN_W'(i) > last_q) begin
          if (!found_hi_c) begin
            found_hi_c = 1'b1;
            hi_idx_c   = OWN_W'(i);
          end
        end else if (!found_lo_c) begin
          found_lo_c = 1'b1;
          lo_idx_c   = OWN_W'(i);
        end
      end
    end
    pick_c = found_hi_c ? hi_idx_c : lo_idx_c;
  end

  // A beat only happens when the owner has data and the FIFO has room
  always_comb begin
    beat_c = busy_q & owner_req_c & ~fifo_full;
    end_c  = ~owner_req_c | (beat_c & (count_q == CNT_W'(MAX_BURST - 1)));
  end

  // Next-state: grant on request, hold burst, re-grant without a bubble at burst end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    count_d = count_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_GRANT;
          grant_d = NREQ'(1) << pick_c;
          count_d = '0;
          last_d  = pick_c;
        end
      end
      S_GRANT: begin
        if (!end_c) begin
          count_d = count_q + CNT_W'(beat_c);
        end else if (|req) begin
          grant_d = NREQ'(1) << pick_c;
          count_d = '0;
          last_d  = pick_c;
        end else begin
          state_d = S_IDLE;
          grant_d = '0;
          count_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        count_d = '0;
      end
    endcase
    busy_d = (state_d == S_GRANT);
  end

  // State registers with synchronous reset; requester 0 wins first after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      count_q <= '0;
      last_q  <= OWN_W'(NREQ - 1);
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      count_q <= count_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign grant    = grant_q;
  assign busy     = busy_q;
  assign fifo_wr  = beat_c;
  assign ack      = grant_q & {NREQ{beat_c}};
  assign fifo_din = busy_q ? din_sel_c : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, a held-request loop, and a randomized model run.
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] din;
  logic                  fifo_full;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       ack;
  logic                  fifo_wr;
  logic [WIDTH-1:0]      fifo_din;
  logic                  busy;

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .din      (din),
    .fifo_full(fifo_full),
    .grant    (grant),
    .ack      (ack),
    .fifo_wr  (fifo_wr),
    .fifo_din (fifo_din),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  ack;
    logic             wr;
    logic [WIDTH-1:0] dout;
    logic             busy;
  } exp_t;

  typedef struct {
    logic            rst;
    logic [NREQ-1:0] req;
    logic            full;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] ack;
    logic            busy;
  } vec_t;

  exp_t  sb_q[$];
  vec_t  tbl[35];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  string phase    = "init";

  logic [NREQ-1:0] obs_grant, obs_ack;
  logic            obs_wr;

  // Reference model state
  int m_busy, m_owner, m_cnt, m_last;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s/%s cycle %0d: got %h expected %h", phase, name, cyc, act, expv);
  endtask

  function automatic logic [WIDTH-1:0] slice_of(input logic [NREQ-1:0] g,
                                                input logic [NREQ*WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++) if (g[i]) r = r | d[i*WIDTH +: WIDTH];
    return r;
  endfunction

  function automatic exp_t from_vec(input vec_t v, input logic [NREQ*WIDTH-1:0] d);
    exp_t e;
    e.grant = v.grant;
    e.ack   = v.ack;
    e.wr    = |v.ack;
    e.dout  = slice_of(v.grant, d);
    e.busy  = v.busy;
    return e;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (last + k) % NREQ;
      if (v[idx]) return idx;
    end
    return last;
  endfunction

  function automatic exp_t model_out(input logic [NREQ-1:0] rq, input logic [NREQ*WIDTH-1:0] d,
                                     input logic f);
    exp_t e;
    logic beat;
    e.busy  = (m_busy != 0);
    e.grant = (m_busy != 0) ? (NREQ'(1) << m_owner) : '0;
    beat    = (m_busy != 0) && rq[m_owner] && !f;
    e.ack   = beat ? e.grant : '0;
    e.wr    = beat;
    e.dout  = (m_busy != 0) ? d[m_owner*WIDTH +: WIDTH] : '0;
    return e;
  endfunction

  task automatic model_update(input logic r, input logic [NREQ-1:0] rq, input logic f);
    logic beat, fin;
    if (r) begin
      m_busy = 0; m_cnt = 0; m_last = NREQ - 1; m_owner = 0;
    end else if (m_busy == 0) begin
      if (|rq) begin
        m_owner = rr_pick(rq, m_last); m_last = m_owner; m_cnt = 0; m_busy = 1;
      end
    end else begin
      beat = rq[m_owner] && !f;
      fin  = !rq[m_owner] || (beat && m_cnt == MAX_BURST - 1);
      if (!fin) begin
        if (beat) m_cnt++;
      end else if (|rq) begin
        m_owner = rr_pick(rq, m_last); m_last = m_owner; m_cnt = 0;
      end else begin
        m_busy = 0; m_cnt = 0;
      end
    end
  endtask

  // Drive one cycle, queue its expectation, compare mid-cycle, advance past the edge
  task automatic step(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ*WIDTH-1:0] d,
                      input logic f, input exp_t e);
    exp_t x;
    rst = r; req = rq; din = d; fifo_full = f;
    sb_q.push_back(e);
    @(negedge clk);
    x = sb_q.pop_front();
    obs_grant = grant; obs_ack = ack; obs_wr = fifo_wr;
    cmp("grant",    32'(grant),    32'(x.grant));
    cmp("ack",      32'(ack),      32'(x.ack));
    cmp("fifo_wr",  32'(fifo_wr),  32'(x.wr));
    cmp("fifo_din", 32'(fifo_din), 32'(x.dout));
    cmp("busy",     32'(busy),     32'(x.busy));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [NREQ*WIDTH-1:0] dfix;
    logic [NREQ*WIDTH-1:0] din_v;
    logic [NREQ-1:0]       rq_v, ack_prev;
    logic                  full_v;
    exp_t                  e;
    int                    wait_b[NREQ];
    int                    max_wait, ack_total, wr_total;

    //           rst  req      full grant    ack      busy
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0};
    for (int i = 0; i < 4; i++) begin
      tbl[2+i]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 4'b0001, 1'b1};
      tbl[6+i]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 4'b0010, 1'b1};
      tbl[10+i] = '{1'b0, 4'b1111, 1'b0, 4'b0100, 4'b0100, 1'b1};
      tbl[14+i] = '{1'b0, 4'b1111, 1'b0, 4'b1000, 4'b1000, 1'b1};
    end
    tbl[18] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 4'b0001, 1'b1};
    tbl[19] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 4'b0001, 1'b1};
    tbl[20] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 4'b0000, 1'b1};
    tbl[21] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 4'b0000, 1'b1};
    tbl[22] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 4'b0000, 1'b1};
    tbl[23] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 4'b0001, 1'b1};
    tbl[24] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 4'b0001, 1'b1};
    tbl[25] = '{1'b0, 4'b1111, 1'b0, 4'b0010, 4'b0010, 1'b1};
    tbl[26] = '{1'b0, 4'b1000, 1'b0, 4'b0010, 4'b0000, 1'b1};
    tbl[27] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 4'b1000, 1'b1};
    tbl[28] = '{1'b0, 4'b0100, 1'b0, 4'b1000, 4'b0000, 1'b1};
    tbl[29] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1};
    tbl[30] = '{1'b1, 4'b1111, 1'b1, 4'b0100, 4'b0000, 1'b1};
    tbl[31] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[32] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 4'b0001, 1'b1};
    tbl[33] = '{1'b0, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b1};
    tbl[34] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};

    dfix = 32'hA3A2_A1A0;
    rst = 1'b1; req = '0; din = '0; fifo_full = 1'b0;
    @(posedge clk);
    #1;

    phase = "table";
    for (int t = 0; t < 35; t++) step(tbl[t].rst, tbl[t].req, dfix, tbl[t].full, from_vec(tbl[t], dfix));

    // Sole requester keeps its grant across burst boundaries with no idle bubble
    phase = "sole_req2";
    e = '{grant: 4'b0000, ack: 4'b0000, wr: 1'b0, dout: 8'h00, busy: 1'b0};
    step(1'b0, 4'b0100, dfix, 1'b0, e);
    e = '{grant: 4'b0100, ack: 4'b0100, wr: 1'b1, dout: 8'hA2, busy: 1'b1};
    for (int t = 0; t < 3 * MAX_BURST + 1; t++) step(1'b0, 4'b0100, dfix, 1'b0, e);

    // Reset during the burst of owner 2
    phase = "rst_mid";
    e = '{grant: 4'b0100, ack: 4'b0000, wr: 1'b0, dout: 8'hA2, busy: 1'b1};
    step(1'b1, 4'b0000, dfix, 1'b1, e);
    model_update(1'b1, '0, 1'b0);

    phase = "random";
    rq_v = '0; ack_prev = '0; din_v = '0;
    max_wait = 0; ack_total = 0; wr_total = 0;
    for (int i = 0; i < NREQ; i++) wait_b[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(rq_v[i] && !ack_prev[i])) begin
          rq_v[i] = ($urandom_range(0, 99) < 45);
          din_v[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
      end
      full_v = ($urandom_range(0, 99) < 25);
      e = model_out(rq_v, din_v, full_v);
      step(1'b0, rq_v, din_v, full_v, e);
      ack_prev = e.ack;
      model_update(1'b0, rq_v, full_v);
      cmp("grant_onehot0", 32'($onehot0(obs_grant)), 32'd1);
      cmp("wr_while_full", 32'(obs_wr & full_v), 32'd0);
      cmp("ack_onehot0",   32'($onehot0(obs_ack)), 32'd1);
      ack_total += $countones(obs_ack);
      wr_total  += int'(obs_wr);
      for (int i = 0; i < NREQ; i++) begin
        if (obs_grant[i]) wait_b[i] = 0;
        else if (rq_v[i] && obs_wr) wait_b[i]++;
        if (wait_b[i] > max_wait) max_wait = wait_b[i];
      end
    end
    cmp("ack_vs_wr_count", 32'(ack_total), 32'(wr_total));
    cmp("max_wait_bound", 32'(max_wait <= (NREQ - 1) * MAX_BURST), 32'd1);
    cmp("writes_seen", 32'(wr_total > 1000), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
